// File: rtl/instruction_fetch_pkg.sv
// Shared fetch definitions: default widths, opcode constants, NOP word and fetch-state enum.
package instruction_fetch_pkg;

  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_CNT_WIDTH  = 16;

  // Opcode field values; fetch itself never decodes them.
  localparam logic [3:0] OP_ADD  = 4'b0100;
  localparam logic [3:0] OP_INC  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0111;
  localparam logic [3:0] OP_BRN  = 4'b1011;
  localparam logic [3:0] OP_LD   = 4'b1110;
  localparam logic [3:0] OP_SVPC = 4'b1111;

  localparam logic [31:0] NOP_WORD = 32'h0;

  // FILL: nothing valid in flight; PRIME: one valid fetch in flight; RUN: output valid.
  typedef enum logic [1:0] {
    FILL  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/instruction_fetch.sv
// Instruction fetch: owns the PC, issues addresses to a 1-cycle synchronous memory,
// registers the returned word for decode, handles stall and branch redirect.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int                    DATA_WIDTH = DEF_DATA_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_target,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0] imem_data,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  output logic                  instr_valid,
  output logic [CNT_WIDTH-1:0]  issue_count
);

  logic [ADDR_WIDTH-1:0] pc_q;
  logic [ADDR_WIDTH-1:0] inflight_pc_q;
  logic                  inflight_vld_q;
  fetch_state_e          state, state_next;

  // The FSM state is the single source of both valid flags, so they can never disagree.
  assign inflight_vld_q = (state != FILL);
  assign instr_valid    = (state == RUN);

  // On a held stall edge, replay the in-flight address so the word returned next edge
  // still belongs to inflight_pc_q. A redirect always issues from the PC path.
  assign imem_addr = (stall && !redirect) ? inflight_pc_q : pc_q;

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= FILL;
    else       state <= state_next;
  end

  // Next-state: fill the two-stage pipe on non-stall edges; redirect flushes back to FILL.
  always_comb begin
    state_next = state;
    if (redirect) begin
      state_next = FILL;
    end else if (!stall) begin
      unique case (state)
        FILL:    state_next = PRIME;
        PRIME:   state_next = RUN;
        RUN:     state_next = RUN;
        default: state_next = FILL;
      endcase
    end
  end

  // PC and in-flight address: advance on normal edges, reload on redirect, hold on stall.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      inflight_pc_q <= RESET_PC;
    end else if (redirect) begin
      pc_q <= redirect_target;
    end else if (!stall) begin
      inflight_pc_q <= pc_q;
      pc_q          <= pc_q + 1'b1;
    end
  end

  // Output word register: capture memory data on normal edges; held (stale) otherwise.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      instr    <= '0;
      instr_pc <= '0;
    end else if (!stall && !redirect) begin
      instr    <= imem_data;
      instr_pc <= inflight_pc_q;
    end
  end

  // Count consumed instructions, including the one consumed on a non-stalled redirect edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                    issue_count <= '0;
    else if (instr_valid && !stall) issue_count <= issue_count + 1'b1;
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Randomized bench for instruction_fetch against a stream-level reference model.
module tb_instruction_fetch;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int CW = 16;

  logic          clock = 1'b0;
  logic          reset;
  logic          stall;
  logic          redirect;
  logic [AW-1:0] redirect_target;
  logic [AW-1:0] imem_addr;
  logic [DW-1:0] imem_data;
  logic [DW-1:0] instr;
  logic [AW-1:0] instr_pc;
  logic          instr_valid;
  logic [CW-1:0] issue_count;

  always #5 clock = ~clock;

  instruction_fetch #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RESET_PC(8'd0), .CNT_WIDTH(CW)
  ) dut (
    .clock(clock), .reset(reset), .stall(stall), .redirect(redirect),
    .redirect_target(redirect_target), .imem_addr(imem_addr), .imem_data(imem_data),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid), .issue_count(issue_count)
  );

  function automatic logic [31:0] word(input logic [7:0] a);
    return {8'hA5, 16'h0, a};
  endfunction

  // Behavioural memory: one-edge read latency.
  always @(posedge clock) imem_data <= word(imem_addr);

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: the delivered stream is consecutive addresses from the last
  // reset/redirect target; output becomes valid after two advancing edges.
  logic [7:0]  m_next;   // next address to be delivered
  int          m_warm;   // advancing edges since reset/redirect, saturates at 2
  logic        m_vld;
  logic [7:0]  m_pc;
  logic [15:0] m_cnt;

  task automatic model_reset();
    m_next = 8'd0; m_warm = 0; m_vld = 1'b0; m_pc = 8'd0; m_cnt = 16'd0;
  endtask

  task automatic model_edge(input logic s, input logic r, input logic [7:0] t);
    if (m_vld && !s) m_cnt++;
    if (r) begin
      m_vld = 1'b0; m_next = t; m_warm = 0;
    end else if (!s) begin
      if (m_warm < 2) m_warm++;
      if (m_warm == 2) begin
        m_vld = 1'b1; m_pc = m_next; m_next++;
      end else begin
        m_vld = 1'b0;
      end
    end
  endtask

  task automatic check_outputs();
    logic [7:0] exp_addr;
    chk("instr_valid", {31'b0, instr_valid}, {31'b0, m_vld});
    chk("issue_count", {16'b0, issue_count}, {16'b0, m_cnt});
    if (m_vld) begin
      chk("instr_pc", {24'b0, instr_pc}, {24'b0, m_pc});
      chk("instr", instr, word(m_pc));
    end
    if (!redirect) begin
      if (!stall) begin
        exp_addr = m_next + ((m_warm > 0) ? 8'd1 : 8'd0);
        chk("imem_addr", {24'b0, imem_addr}, {24'b0, exp_addr});
      end else if (m_warm > 0) begin
        chk("imem_addr_stall", {24'b0, imem_addr}, {24'b0, m_next});
      end
    end
  endtask

  task automatic step(input logic s, input logic r, input logic [7:0] t);
    @(negedge clock);
    reset = 1'b0; stall = s; redirect = r; redirect_target = t;
    #1;
    check_outputs();
    model_edge(s, r, t);
  endtask

  // Reset is asserted away from the edge so the asynchronous clear is observed at once.
  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_target = 8'd0;
    #1;
    chk("rst_instr", instr, 32'h0);
    chk("rst_instr_pc", {24'b0, instr_pc}, 32'h0);
    chk("rst_valid", {31'b0, instr_valid}, 32'h0);
    chk("rst_count", {16'b0, issue_count}, 32'h0);
    chk("rst_imem_addr", {24'b0, imem_addr}, 32'h0);
    model_reset();
  endtask

  initial begin
    logic [7:0] tgt;
    logic [7:0] tlist [5];
    tlist[0] = 8'd37; tlist[1] = 8'd10; tlist[2] = 8'd254; tlist[3] = 8'd255; tlist[4] = 8'd0;
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_target = 8'd0;
    model_reset();
    do_reset();

    // Fill and stream from PC 0, then stall around instr_pc 5.
    repeat (7) step(1'b0, 1'b0, 8'd0);
    repeat (3) step(1'b1, 1'b0, 8'd0);
    repeat (4) step(1'b0, 1'b0, 8'd0);
    // Redirect to 37 while running.
    step(1'b0, 1'b1, 8'd37);
    repeat (5) step(1'b0, 1'b0, 8'd0);
    // Redirect coinciding with stall, stall held a while longer.
    step(1'b1, 1'b1, 8'd10);
    repeat (2) step(1'b1, 1'b0, 8'd0);
    repeat (5) step(1'b0, 1'b0, 8'd0);
    // Wrap from 254.
    step(1'b0, 1'b1, 8'd254);
    repeat (6) step(1'b0, 1'b0, 8'd0);
    // Back-to-back redirects: last target wins.
    step(1'b0, 1'b1, 8'd100);
    step(1'b0, 1'b1, 8'd200);
    repeat (4) step(1'b0, 1'b0, 8'd0);
    // Reset mid-run, then restart.
    repeat (20) step(1'b0, 1'b0, 8'd0);
    do_reset();
    repeat (5) step(1'b0, 1'b0, 8'd0);

    // Random traffic with occasional redirects and resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
      end else begin
        tgt = ($urandom_range(0, 1) == 0) ? tlist[$urandom_range(0, 4)] : 8'($urandom);
        step(($urandom_range(0, 3) == 0), ($urandom_range(0, 11) == 0), tgt);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
